// File: rtl/dac_pkg.sv
// Shared constants, state encoding and helpers for the DAC frame sequencer.
package dac_pkg;

   localparam int unsigned DATA_W       = 12;
   localparam int unsigned ADDR_W       = 4;
   localparam int unsigned CMD_W        = 4;
   localparam int unsigned NUM_CH       = 4;
   localparam int unsigned PHASE_OFFSET = 1024;
   localparam int unsigned STATE_W      = 3;

   localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE = 4'h3;
   localparam logic [CMD_W-1:0] CMD_NOP          = 4'hF;

   localparam logic [ADDR_W-1:0] ADDR_CH0 = 4'd0;
   localparam logic [ADDR_W-1:0] ADDR_CH1 = 4'd1;
   localparam logic [ADDR_W-1:0] ADDR_CH2 = 4'd2;
   localparam logic [ADDR_W-1:0] ADDR_CH3 = 4'd3;

   localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] S_WAIT_TICK = 3'd1;
   localparam logic [STATE_W-1:0] S_LOAD      = 3'd2;
   localparam logic [STATE_W-1:0] S_TRIG      = 3'd3;
   localparam logic [STATE_W-1:0] S_WAIT_BUSY = 3'd4;
   localparam logic [STATE_W-1:0] S_WAIT_DONE = 3'd5;
   localparam logic [STATE_W-1:0] S_NEXT      = 3'd6;

   // Word presented to the SPI stage for one channel update.
   typedef struct packed {
      logic [CMD_W-1:0]  command;
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] data;
   } dac_word_t;

   // Lowest set mask bit at or above 'from'; returns NUM_CH when none remains.
   function automatic logic [2:0] next_ch(input logic [3:0] mask, input logic [2:0] from);
      logic [2:0] res;
      res = 3'(NUM_CH);
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (mask[i] && (3'(i) >= from)) res = 3'(i);
      end
      return res;
   endfunction

   function automatic logic [ADDR_W-1:0] ch_addr(input logic [1:0] ch);
      logic [ADDR_W-1:0] a;
      case (ch)
         2'd0:    a = ADDR_CH0;
         2'd1:    a = ADDR_CH1;
         2'd2:    a = ADDR_CH2;
         default: a = ADDR_CH3;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/dac_rate_tick.sv
// Enable-gated frame-rate divider: one-cycle tick every RATE_DIV cycles while en is high.
module dac_rate_tick #(
   parameter int unsigned RATE_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = 24;

   logic [CNT_W-1:0] cnt;
   logic             wrap_c;

   assign wrap_c = (cnt == CNT_W'(RATE_DIV - 1));
   assign tick_c = en && wrap_c;

   // Counter is held at zero while disabled so the first tick lands RATE_DIV-1 cycles after enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || wrap_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Periodic per-channel DAC update sequencer feeding the SPI stage (ramp or constant level).
module dac_frame_sequencer
   import dac_pkg::*;
#(
   parameter int unsigned       RATE_DIV = 50000,
   parameter logic [NUM_CH-1:0] CH_MASK  = 4'b1111,
   parameter logic [DATA_W-1:0] STEP     = 12'd16,
   parameter int unsigned       TIMEOUT  = 4096
) (
   input  logic              CLK50MHZ,
   input  logic              RST,
   input  logic              en,
   input  logic              mode,
   input  logic [DATA_W-1:0] level,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] address,
   output logic [CMD_W-1:0]  command,
   output logic              dactrig,
   input  logic              dacdone,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic                tick_c;
   logic [STATE_W-1:0]  state, state_d;
   logic [1:0]          ch, ch_d;
   logic [DATA_W-1:0]   ramp, ramp_d;
   logic [TO_W-1:0]     to_cnt, to_cnt_d;
   dac_word_t           word_q, word_d;
   logic                dactrig_d, busy_d, overrun_d, timeout_err_d;
   logic [15:0]         frame_cnt_d;
   logic [2:0]          first_c, rest_c;
   logic                to_expired_c;

   dac_rate_tick #(
      .RATE_DIV (RATE_DIV)
   ) u_rate_tick (
      .clk    (CLK50MHZ),
      .rst_n  (RST),
      .en     (en),
      .tick_c (tick_c)
   );

   assign first_c      = next_ch(CH_MASK, 3'd0);
   assign rest_c       = next_ch(CH_MASK, 3'(ch) + 3'd1);
   assign to_expired_c = (to_cnt == TO_W'(TIMEOUT - 1));

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state;
      ch_d          = ch;
      ramp_d        = ramp;
      to_cnt_d      = to_cnt;
      word_d        = word_q;
      overrun_d     = overrun;
      timeout_err_d = timeout_err;
      frame_cnt_d   = frame_cnt;

      if (tick_c && (state != S_IDLE) && (state != S_WAIT_TICK)) overrun_d = 1'b1;

      case (state)
         S_IDLE: begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
            if (en) state_d = S_WAIT_TICK;
         end
         S_WAIT_TICK: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (tick_c) begin
               if (first_c < 3'(NUM_CH)) begin
                  ch_d    = 2'(first_c);
                  state_d = S_LOAD;
               end else begin
                  frame_cnt_d = frame_cnt + 16'd1;
               end
            end
         end
         S_LOAD: begin
            state_d = S_TRIG;
         end
         S_TRIG: begin
            to_cnt_d = '0;
            state_d  = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!dacdone) begin
               to_cnt_d = '0;
               state_d  = S_WAIT_DONE;
            end else if (to_expired_c) begin
               timeout_err_d = 1'b1;
               state_d       = S_WAIT_TICK;
            end else begin
               to_cnt_d = to_cnt + TO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (dacdone) begin
               state_d = S_NEXT;
            end else if (to_expired_c) begin
               timeout_err_d = 1'b1;
               state_d       = S_WAIT_TICK;
            end else begin
               to_cnt_d = to_cnt + TO_W'(1);
            end
         end
         S_NEXT: begin
            // An unfinished frame is dropped without counting when en falls.
            if (rest_c < 3'(NUM_CH)) begin
               if (en) begin
                  ch_d    = 2'(rest_c);
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               frame_cnt_d = frame_cnt + 16'd1;
               ramp_d      = ramp + STEP;
               state_d     = en ? S_WAIT_TICK : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The output word is captured on entry to LOAD and held through the handshake.
      if (state_d == S_LOAD) begin
         word_d.address = ch_addr(ch_d);
         word_d.data    = mode ? level : ramp + DATA_W'(PHASE_OFFSET * 32'(ch_d));
      end

      dactrig_d = (state_d == S_TRIG);
      busy_d    = (state_d != S_IDLE) && (state_d != S_WAIT_TICK);
   end

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         state       <= S_IDLE;
         ch          <= 2'd0;
         ramp        <= '0;
         to_cnt      <= '0;
         word_q      <= '{command: CMD_WRITE_UPDATE, address: ADDR_CH0, data: '0};
         dactrig     <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_d;
         ch          <= ch_d;
         ramp        <= ramp_d;
         to_cnt      <= to_cnt_d;
         word_q      <= word_d;
         dactrig     <= dactrig_d;
         busy        <= busy_d;
         overrun     <= overrun_d;
         timeout_err <= timeout_err_d;
         frame_cnt   <= frame_cnt_d;
      end
   end

   assign data    = word_q.data;
   assign address = word_q.address;
   assign command = word_q.command;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed scoreboard bench for dac_frame_sequencer with a simple SPI-stage responder.
module tb_dac_frame_sequencer;

   typedef struct packed {
      logic [3:0]  addr;
      logic [11:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        mode = 1'b0;
   logic [11:0] level = 12'd0;
   logic [11:0] data;
   logic [3:0]  address;
   logic [3:0]  command;
   logic        dactrig;
   logic        dacdone;
   logic        busy;
   logic        overrun;
   logic        timeout_err;
   logic [15:0] frame_cnt;

   int          passed = 0;
   int          total = 0;
   int          trig_count = 0;
   logic        trig_prev = 1'b0;
   exp_t        exp_q[$];
   exp_t        e;
   logic [11:0] ramp_m = 12'd0;

   int          spi_busy = 40;
   logic        spi_hang = 1'b0;
   int          spi_cnt = 0;

   always #5 clk = ~clk;

   dac_frame_sequencer #(
      .RATE_DIV (100),
      .CH_MASK  (4'b1111),
      .STEP     (12'd16),
      .TIMEOUT  (64)
   ) dut (
      .CLK50MHZ    (clk),
      .RST         (rst_n),
      .en          (en),
      .mode        (mode),
      .level       (level),
      .data        (data),
      .address     (address),
      .command     (command),
      .dactrig     (dactrig),
      .dacdone     (dacdone),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .frame_cnt   (frame_cnt)
   );

   // SPI stage: goes busy for spi_busy cycles after each trigger, or ignores it when hung.
   always @(posedge clk) begin
      if (dactrig && !spi_hang) spi_cnt <= spi_busy;
      else if (spi_cnt != 0) spi_cnt <= spi_cnt - 1;
   end
   assign dacdone = (spi_cnt == 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push_frame();
      for (int k = 0; k < 4; k++) exp_q.push_back('{addr: 4'(k), data: 12'(32'(ramp_m) + k * 1024)});
      ramp_m = 12'(32'(ramp_m) + 16);
   endtask

   task automatic push_level_frame(input logic [11:0] lvl);
      for (int k = 0; k < 4; k++) exp_q.push_back('{addr: 4'(k), data: lvl});
      ramp_m = 12'(32'(ramp_m) + 16);
   endtask

   task automatic wait_frame_cnt(input logic [15:0] target, input int budget);
      int n = 0;
      while (frame_cnt !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_frame_cnt", 32'(frame_cnt), 32'(target));
   endtask

   task automatic wait_trig(input logic [3:0] addr, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(dactrig === 1'b1 && address === addr) && n < budget);
      check("wait_trig", 32'({dactrig, address}), 32'({1'b1, addr}));
   endtask

   // Monitor: every trigger pops one expected channel word.
   always @(negedge clk) begin
      if (rst_n && dactrig) begin
         trig_count++;
         check("trig_single_cycle", 32'(trig_prev), 32'(0));
         check("trig_expected", 32'(exp_q.size() != 0), 32'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("trig_address", 32'(address), 32'(e.addr));
            check("trig_data", 32'(data), 32'(e.data));
            check("trig_command", 32'(command), 32'(4'h3));
         end
      end
      trig_prev = rst_n && dactrig;
   end

   initial begin
      int n;
      int snap;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data), 32'(0));
      check("rst_address", 32'(address), 32'(0));
      check("rst_command", 32'(command), 32'(4'h3));
      check("rst_dactrig", 32'(dactrig), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      check("rst_timeout_err", 32'(timeout_err), 32'(0));
      check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Two ramp frames with a slow SPI stage; frames outlast the tick period
      spi_busy = 40;
      push_frame();
      push_frame();
      en = 1'b1;
      wait_frame_cnt(16'd2, 1000);
      en = 1'b0;
      check("ovr_set", 32'(overrun), 32'(1));
      repeat (2) @(negedge clk);
      check("ovr_cleared_by_idle", 32'(overrun), 32'(0));
      check("ovr_busy_idle", 32'(busy), 32'(0));
      check("ovr_queue_drained", 32'(exp_q.size()), 32'(0));

      // Level mode frame with a fast SPI stage
      spi_busy = 3;
      mode = 1'b1;
      level = 12'hABC;
      push_level_frame(12'hABC);
      en = 1'b1;
      wait_frame_cnt(16'd3, 400);
      en = 1'b0;
      mode = 1'b0;
      check("lvl_no_overrun", 32'(overrun), 32'(0));
      check("lvl_queue_drained", 32'(exp_q.size()), 32'(0));
      repeat (2) @(negedge clk);

      // Long ramp run: ramp and channel phase offsets wrap modulo 4096
      for (int f = 0; f < 256; f++) push_frame();
      en = 1'b1;
      wait_frame_cnt(16'd259, 30000);
      en = 1'b0;
      check("wrap_queue_drained", 32'(exp_q.size()), 32'(0));
      check("wrap_ramp_model", 32'(ramp_m), 32'(48));
      repeat (2) @(negedge clk);

      // Handshake timeout: SPI never goes busy
      spi_hang = 1'b1;
      exp_q.push_back('{addr: 4'd0, data: ramp_m});
      en = 1'b1;
      wait_trig(4'd0, 300);
      @(posedge clk);
      n = 0;
      while (timeout_err !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("to_latency", 32'(n), 32'(64));
      check("to_busy_wait_tick", 32'(busy), 32'(0));
      check("to_frame_cnt", 32'(frame_cnt), 32'(259));
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      check("to_cleared_by_idle", 32'(timeout_err), 32'(0));
      spi_hang = 1'b0;

      // en drop during channel 1 handshake
      spi_busy = 40;
      exp_q.push_back('{addr: 4'd0, data: ramp_m});
      exp_q.push_back('{addr: 4'd1, data: 12'(32'(ramp_m) + 1024)});
      snap = trig_count;
      en = 1'b1;
      wait_trig(4'd1, 400);
      repeat (5) @(negedge clk);
      en = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drop_busy", 32'(busy), 32'(0));
      check("drop_dacdone", 32'(dacdone), 32'(1));
      check("drop_address_held", 32'(address), 32'(1));
      check("drop_frame_cnt", 32'(frame_cnt), 32'(259));
      repeat (250) @(negedge clk);
      check("drop_trig_count", 32'(trig_count - snap), 32'(2));
      check("drop_queue_drained", 32'(exp_q.size()), 32'(0));

      // Asynchronous reset in the middle of WAIT_DONE
      exp_q.push_back('{addr: 4'd0, data: ramp_m});
      en = 1'b1;
      wait_trig(4'd0, 300);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_data", 32'(data), 32'(0));
      check("arst_address", 32'(address), 32'(0));
      check("arst_command", 32'(command), 32'(4'h3));
      check("arst_dactrig", 32'(dactrig), 32'(0));
      check("arst_frame_cnt", 32'(frame_cnt), 32'(0));
      check("arst_overrun", 32'(overrun), 32'(0));
      check("arst_timeout_err", 32'(timeout_err), 32'(0));
      repeat (2) @(negedge clk);
      ramp_m = 12'd0;
      spi_busy = 3;
      rst_n = 1'b1;
      snap = trig_count;
      repeat (90) @(negedge clk);
      check("arst_no_early_trig", 32'(trig_count - snap), 32'(0));
      push_frame();
      wait_frame_cnt(16'd1, 400);
      en = 1'b0;
      check("arst_queue_drained", 32'(exp_q.size()), 32'(0));
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
